// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 24-bit CPU: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath control lines.
module multicycle_control #(
  parameter int CNT_W        = 16,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [3:0]       opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegDst,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             Halted,
  output logic             Illegal,
  output logic             MemFault,
  output logic [CNT_W-1:0] InstrCount,
  output logic [2:0]       State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LW, C_SW, C_BEQ, C_HALT, C_ILL
  } cls_t;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  function automatic cls_t op_class(input logic [3:0] op);
    case (op)
      4'b0000:                            return C_R;
      4'b0001, 4'b0010, 4'b0011, 4'b0100: return C_IALU;
      4'b1000:                            return C_LW;
      4'b1001:                            return C_SW;
      4'b1010:                            return C_BEQ;
      4'b1111:                            return C_HALT;
      default:                            return C_ILL;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q, fault_q;
  logic             retire, set_ill, set_fault;
  cls_t             cls_live, cls_q;
  logic             mem_abort, alu_src_q;
  logic [1:0]       alu_op_q;

  // Zero is consumed by the datapath's PC mux; the sequencer is the same for taken/not-taken.
  logic unused_zero;
  assign unused_zero = Zero;

  assign cls_live  = op_class(opcode);
  assign cls_q     = op_class(op_q);
  assign mem_abort = (state_q == S_MEM) && !MemReady && (wait_q == WAIT_MAX);
  assign alu_src_q = (cls_q == C_IALU) || (cls_q == C_LW) || (cls_q == C_SW);

  always_comb begin
    case (cls_q)
      C_BEQ:   alu_op_q = 2'b01;
      C_R:     alu_op_q = 2'b10;
      C_IALU:  alu_op_q = 2'b11;
      default: alu_op_q = 2'b00;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (Run) state_d = S_DECODE;
      S_DECODE: begin
        if (cls_live == C_HALT)     state_d = S_HALT;
        else if (cls_live == C_ILL) state_d = S_FETCH;
        else                        state_d = S_EXEC;
      end
      S_EXEC: begin
        if ((cls_q == C_LW) || (cls_q == C_SW))     state_d = S_MEM;
        else if ((cls_q == C_R) || (cls_q == C_IALU)) state_d = S_WB;
        else                                          state_d = S_FETCH;
      end
      S_MEM: begin
        if (MemReady)       state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
        else if (mem_abort) state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Memory handshake: MemRead/MemWrite is a request held high in MEM until the
  // cycle MemReady=1 (the access completes in that cycle), or dropped on timeout.
  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegDst    = 1'b0;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = 2'b00;
    retire    = 1'b0;
    set_ill   = 1'b0;
    set_fault = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_FETCH:  IRWrite = Run;
        S_DECODE: begin
          if (cls_live == C_ILL) begin
            PCWrite = 1'b1;
            set_ill = 1'b1;
          end
        end
        S_EXEC: begin
          ALUSrc = alu_src_q;
          ALUOp  = alu_op_q;
          if (cls_q == C_BEQ) begin
            Branch  = 1'b1;
            PCWrite = 1'b1;
            retire  = 1'b1;
          end
        end
        S_MEM: begin
          ALUSrc   = 1'b1;
          MemRead  = (cls_q == C_LW) && !mem_abort;
          MemWrite = (cls_q == C_SW) && !mem_abort;
          if (MemReady && (cls_q == C_SW)) begin
            PCWrite = 1'b1;
            retire  = 1'b1;
          end else if (mem_abort) begin
            PCWrite   = 1'b1;
            set_fault = 1'b1;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          RegDst   = (cls_q == C_R);
          MemToReg = (cls_q == C_LW);
          ALUSrc   = alu_src_q;
          ALUOp    = alu_op_q;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q      <= '0;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      if (state_q == S_DECODE) op_q <= opcode;
      // MEM is only entered from EXEC, so clearing there covers every MEM entry.
      if (state_q == S_EXEC)                          wait_q <= '0;
      else if ((state_q == S_MEM) && !MemReady && !mem_abort) wait_q <= wait_q + 8'd1;
      if (retire)    count_q   <= count_q + 1'b1;
      if (set_ill)   illegal_q <= 1'b1;
      if (set_fault) fault_q   <= 1'b1;
    end
  end

  assign Halted     = (state_q == S_HALT);
  assign Illegal    = illegal_q;
  assign MemFault   = fault_q;
  assign InstrCount = count_q;
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and checks state, control lines, counters and sticky flags.
module tb_multicycle_control;

  logic        Clock = 1'b0;
  logic        Reset, Run, Zero, MemReady;
  logic [3:0]  opcode;
  logic        IRWrite, PCWrite, RegDst, Branch, MemRead, MemWrite;
  logic        RegWrite, MemToReg, ALUSrc, Halted, Illegal, MemFault;
  logic [1:0]  ALUOp;
  logic [15:0] InstrCount;
  logic [2:0]  State;
  logic [10:0] ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control #(.CNT_W(16), .MEM_WAIT_MAX(15)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .opcode(opcode), .Zero(Zero),
    .MemReady(MemReady), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Halted(Halted),
    .Illegal(Illegal), .MemFault(MemFault), .InstrCount(InstrCount), .State(State)
  );

  always #5 Clock = ~Clock;

  assign ctrl = {IRWrite, PCWrite, RegDst, Branch, MemRead, MemWrite,
                 RegWrite, MemToReg, ALUSrc, ALUOp};

  // c(ir, pc, rd, br, mr, mw, rw, m2r, as, aop)
  function automatic logic [10:0] c(input logic ir, pc, rd, br, mr, mw, rw, m2r, as,
                                    input logic [1:0] aop);
    return {ir, pc, rd, br, mr, mw, rw, m2r, as, aop};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Checks one cycle at the falling edge, then advances past the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] ex);
    @(negedge Clock);
    check({tag, " state"}, 32'(State), 32'(st));
    check({tag, " ctrl"}, 32'(ctrl), 32'(ex));
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b1; opcode = 4'b0000; Zero = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst state", 32'(State), 32'd0);
    check("rst ctrl forced", 32'(ctrl), 32'd0);
    check("rst count", 32'(InstrCount), 32'd0);
    check("rst flags", 32'({Illegal, MemFault, Halted}), 32'd0);
    Run = 1'b0; Reset = 1'b0;
    @(posedge Clock); #1;

    // R-type
    Run = 1'b1; opcode = 4'b0000;
    cyc("r fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
    Run = 1'b0;
    cyc("r decode", 3'd1, 11'd0);
    cyc("r exec", 3'd2, c(0,0,0,0,0,0,0,0,0,2'b10));
    cyc("r wb", 3'd4, c(0,1,1,0,0,0,1,0,0,2'b10));
    check("r count", 32'(InstrCount), 32'd1);
    cyc("idle0", 3'd0, 11'd0);
    cyc("idle1", 3'd0, 11'd0);

    // LW, two wait cycles; opcode changes after DECODE to prove it is latched
    Run = 1'b1; opcode = 4'b1000; MemReady = 1'b0;
    cyc("lw fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
    Run = 1'b0;
    cyc("lw decode", 3'd1, 11'd0);
    opcode = 4'b0000;
    cyc("lw exec", 3'd2, c(0,0,0,0,0,0,0,0,1,2'b00));
    cyc("lw mem1", 3'd3, c(0,0,0,0,1,0,0,0,1,2'b00));
    cyc("lw mem2", 3'd3, c(0,0,0,0,1,0,0,0,1,2'b00));
    MemReady = 1'b1;
    cyc("lw mem3", 3'd3, c(0,0,0,0,1,0,0,0,1,2'b00));
    MemReady = 1'b0;
    cyc("lw wb", 3'd4, c(0,1,0,0,0,0,1,1,1,2'b00));
    check("lw count", 32'(InstrCount), 32'd2);

    // BEQ taken then not taken
    for (int z = 1; z >= 0; z--) begin
      Run = 1'b1; opcode = 4'b1010; Zero = z[0];
      cyc("beq fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
      Run = 1'b0;
      cyc("beq decode", 3'd1, 11'd0);
      cyc("beq exec", 3'd2, c(0,1,0,1,0,0,0,0,0,2'b01));
      cyc("beq back", 3'd0, 11'd0);
    end
    check("beq count", 32'(InstrCount), 32'd4);

    // SW with MemReady stuck low: 15 request cycles, then abort
    Run = 1'b1; opcode = 4'b1001; MemReady = 1'b0;
    cyc("swf fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
    Run = 1'b0;
    cyc("swf decode", 3'd1, 11'd0);
    cyc("swf exec", 3'd2, c(0,0,0,0,0,0,0,0,1,2'b00));
    for (int i = 0; i < 15; i++) cyc("swf mem", 3'd3, c(0,0,0,0,0,1,0,0,1,2'b00));
    cyc("swf abort", 3'd3, c(0,1,0,0,0,0,0,0,1,2'b00));
    check("swf state", 32'(State), 32'd0);
    check("swf fault", 32'(MemFault), 32'd1);
    check("swf count", 32'(InstrCount), 32'd4);

    // SW completing on the first MEM cycle
    Run = 1'b1; opcode = 4'b1001; MemReady = 1'b1;
    cyc("sw fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
    Run = 1'b0;
    cyc("sw decode", 3'd1, 11'd0);
    cyc("sw exec", 3'd2, c(0,0,0,0,0,0,0,0,1,2'b00));
    cyc("sw mem", 3'd3, c(0,1,0,0,0,1,0,0,1,2'b00));
    MemReady = 1'b0;
    check("sw state", 32'(State), 32'd0);
    check("sw count", 32'(InstrCount), 32'd5);

    // LW with MemReady arriving on the last allowed cycle
    Run = 1'b1; opcode = 4'b1000;
    cyc("lwmax fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
    Run = 1'b0;
    cyc("lwmax decode", 3'd1, 11'd0);
    cyc("lwmax exec", 3'd2, c(0,0,0,0,0,0,0,0,1,2'b00));
    for (int i = 0; i < 15; i++) cyc("lwmax mem", 3'd3, c(0,0,0,0,1,0,0,0,1,2'b00));
    MemReady = 1'b1;
    cyc("lwmax last", 3'd3, c(0,0,0,0,1,0,0,0,1,2'b00));
    MemReady = 1'b0;
    cyc("lwmax wb", 3'd4, c(0,1,0,0,0,0,1,1,1,2'b00));
    check("lwmax count", 32'(InstrCount), 32'd6);

    // Illegal opcode skipped
    Run = 1'b1; opcode = 4'b0110;
    cyc("ill fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
    Run = 1'b0;
    cyc("ill decode", 3'd1, c(0,1,0,0,0,0,0,0,0,2'b00));
    check("ill state", 32'(State), 32'd0);
    check("ill flag", 32'(Illegal), 32'd1);
    check("ill count", 32'(InstrCount), 32'd6);

    // HALT, Run held high
    Run = 1'b1; opcode = 4'b1111;
    cyc("halt fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
    cyc("halt decode", 3'd1, 11'd0);
    check("halted", 32'(Halted), 32'd1);
    cyc("halt hold0", 3'd5, 11'd0);
    cyc("halt hold1", 3'd5, 11'd0);
    check("halt sticky", 32'({Halted, Illegal, MemFault}), 32'h7);
    check("halt count", 32'(InstrCount), 32'd6);

    // Reset out of HALT
    @(negedge Clock);
    Reset = 1'b1; Run = 1'b0;
    #1;
    check("rst2 state", 32'(State), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("rst2 count", 32'(InstrCount), 32'd0);
    check("rst2 flags", 32'({Halted, Illegal, MemFault}), 32'd0);

    // Reset during a pending LW request
    Run = 1'b1; opcode = 4'b1000; MemReady = 1'b0;
    cyc("lwr fetch", 3'd0, c(1,0,0,0,0,0,0,0,0,2'b00));
    Run = 1'b0;
    cyc("lwr decode", 3'd1, 11'd0);
    cyc("lwr exec", 3'd2, c(0,0,0,0,0,0,0,0,1,2'b00));
    cyc("lwr mem1", 3'd3, c(0,0,0,0,1,0,0,0,1,2'b00));
    check("lwr pending", 32'(MemRead), 32'd1);
    Reset = 1'b1;
    #1;
    check("lwr memread drop", 32'(MemRead), 32'd0);
    check("lwr ctrl drop", 32'(ctrl), 32'd0);
    check("lwr state", 32'(State), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("lwr after state", 32'(State), 32'd0);
    check("lwr after count", 32'(InstrCount), 32'd0);
    check("lwr after flags", 32'({Halted, Illegal, MemFault}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the 24-bit CPU datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the datapath control lines (RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUOp) plus instruction-register and PC write enables. It sits between the 4-bit opcode from the datapath and the datapath control inputs, and adds a data-memory ready handshake with a timeout, halt/illegal detection and a retired-instruction counter.

## Interface
- CNT_W, 16, width of retired-instruction counter
- MEM_WAIT_MAX, 15, maximum MEM cycles with MemReady low before abort (1..255)

- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clock and reset are one clock domain, reset async active-high (decided)
- Run  in  1  permits a new fetch; sampled only in FETCH
- opcode  in  4  instruction[23:20] from datapath, valid from DECODE onward
- Zero  in  1  ALU zero flag, valid in EXEC
- MemReady  in  1  data memory completed access this cycle
- IRWrite, PCWrite  out  1 each  instruction register / PC load enables
- RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc  out  1 each  datapath controls
- ALUOp  out  2  00 add, 01 sub, 10 R-type funct, 11 immediate op
- Halted  out  1  in HALT state
- Illegal  out  1  sticky: undefined opcode seen
- MemFault  out  1  sticky: memory timeout occurred
- InstrCount  out  CNT_W  retired instructions, wraps
- State  out  3  current state encoding

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6/7 go to FETCH.
- Opcode map:
  - 0000 R-type
  - 0001 ADDI, 0010 ANDI, 0011 ORI, 0100 SLTI (I-ALU)
  - 1000 LW, 1001 SW, 1010 BEQ, 1111 HALT
  - all others illegal
- opcode is latched into an internal register in DECODE. EXEC/MEM/WB decode from the latched copy.
- FETCH:
  - Run=1: IRWrite=1, then go to DECODE.
  - Run=0: all outputs 0, stay in FETCH.
- DECODE:
  - Legal non-HALT opcode: go to EXEC.
  - HALT: go to HALT.
  - Illegal: PCWrite=1 (skip), Illegal set, go to FETCH, no retire.
- EXEC:
  - ALUSrc=1 for I-ALU/LW/SW.
  - ALUOp per class: LW/SW 00, BEQ 01, R 10, I-ALU 11.
  - BEQ: Branch=1, PCWrite=1, retire, go to FETCH. The datapath selects the target when Zero=1.
  - LW/SW: go to MEM. R and I-ALU: go to WB.
- MEM:
  - ALUSrc=1 and ALUOp=00 held throughout.
  - LW holds MemRead=1; SW holds MemWrite=1, until MemReady=1.
  - On MemReady=1: LW goes to WB; SW asserts PCWrite=1 in the same cycle (Mealy), retires, and goes to FETCH.
  - Wait counter clears on MEM entry and increments each cycle MemReady=0.
  - Abort when the counter reaches MEM_WAIT_MAX with MemReady=0: drop MemRead/MemWrite, PCWrite=1, MemFault set, go to FETCH, no retire.
  - MemReady=1 on the abort cycle counts as success.
- WB:
  - RegWrite=1 and PCWrite=1, retire, go to FETCH.
  - RegDst=1 for R-type only. MemToReg=1 for LW only.
  - ALUSrc/ALUOp held from EXEC.
- HALT: Halted=1, all other controls 0. Exit only via Reset.
- Retire: InstrCount increments by 1 modulo 2^CNT_W.
- PCWrite pulses exactly once per instruction, including skips.

## Timing
- Reset asserted: State=FETCH, wait counter/latched opcode/InstrCount=0, Illegal=MemFault=Halted=0. All control outputs forced 0 while Reset=1.
- Controls are combinational from state, latched opcode, MemReady and Run. State, counters and flags update on the rising edge of Clock.
- Cycle counts, FETCH through last cycle:
  - BEQ: 3
  - R-type and I-ALU: 4
  - SW: 4+k
  - LW: 5+k
  - k = MemReady-low cycles in MEM
- Reset mid-instruction (any state, including MEM with a pending request) drops all controls asynchronously. No retire and no write for that instruction.
- Sticky flags clear only on Reset. Illegal and MemFault may both be set.

## Test plan
- Run=1, opcode=0000 → states 0,1,2,4. IRWrite in cycle 1. WB has RegWrite=RegDst=PCWrite=1, ALUOp=10. InstrCount 0→1.
- LW (1000), MemReady low 2 cycles then high → MEM lasts 3 cycles with MemRead=1. WB has MemToReg=1, RegWrite=1. Total 7 cycles.
- BEQ (1010), Zero=1 and then Zero=0 → EXEC has Branch=1, PCWrite=1, ALUOp=01 in both cases. Returns to FETCH after 3 cycles. InstrCount +2.
- SW (1001), MemReady held 0, MEM_WAIT_MAX=15 → MemWrite high 15 cycles. Abort cycle has MemWrite=0, PCWrite=1. MemFault=1, InstrCount unchanged.
- Opcode 0110 → DECODE PCWrite=1, Illegal=1, no RegWrite. Next opcode 1111 → Halted=1, Run ignored.
- Reset asserted during MEM of LW → MemRead drops immediately. After release: State=0, InstrCount=0, flags 0.
